// File: rtl/alu_mul_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// alu_mul_sequencer_pkg : shared ALU control codes, ALUOp codes, MUL FSM states
// Revision: 1.0
// ============================================================================
package alu_mul_sequencer_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 3;

  localparam logic [CTRL_W-1:0] ALU_AND  = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_OR   = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 3'b011;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 3'b100;
  localparam logic [CTRL_W-1:0] ALU_MUL  = 3'b101;
  localparam logic [CTRL_W-1:0] ALU_SLLI = 3'b110;
  localparam logic [CTRL_W-1:0] ALU_SRAI = 3'b111;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_mul_sequencer_if.sv
`default_nettype none
// ============================================================================
// alu_mul_sequencer_if : EX-stage <-> multiply sequencer signal bundle
// Revision: 1.0
// ============================================================================
interface alu_mul_sequencer_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 3
);
  logic              valid_i;
  logic [CTRL_W-1:0] alu_ctrl_i;
  logic [XLEN-1:0]   rs1_data_i;
  logic [XLEN-1:0]   rs2_data_i;
  logic              flush_i;
  logic              stall_o;
  logic              busy_o;
  logic              result_valid_o;
  logic [XLEN-1:0]   result_o;

  modport master (
    output valid_i, alu_ctrl_i, rs1_data_i, rs2_data_i, flush_i,
    input  stall_o, busy_o, result_valid_o, result_o
  );

  modport slave (
    input  valid_i, alu_ctrl_i, rs1_data_i, rs2_data_i, flush_i,
    output stall_o, busy_o, result_valid_o, result_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_mul_sequencer_dp.sv
`default_nettype none
// ============================================================================
// mul_shift_add_dp : shift-add multiply datapath (acc, mcand, mplier, cnt)
// Revision: 1.0
// ============================================================================
module mul_shift_add_dp #(
  parameter int XLEN = 32
) (
  input  wire logic            clk_i,
  input  wire logic            rst_i,
  input  wire logic            load_i,
  input  wire logic            step_i,
  input  wire logic [XLEN-1:0] mcand_i,
  input  wire logic [XLEN-1:0] mplier_i,
  output logic      [XLEN-1:0] acc_nxt_o,
  output logic                 last_o
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      cnt_d    = '0;
    end else if (step_i) begin
      acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // Post-step accumulator lets the sequencer capture the product on DONE entry.
  assign acc_nxt_o = acc_d;
  assign last_o    = (cnt_q == CNT_W'(XLEN - 1));

endmodule
`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// alu_mul_sequencer : stalls the pipeline while an iterative MUL runs in EX
// Revision: 1.0
// ============================================================================
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int                XLEN     = alu_mul_sequencer_pkg::XLEN,
  parameter int                CTRL_W   = alu_mul_sequencer_pkg::CTRL_W,
  parameter logic [CTRL_W-1:0] MUL_CODE = alu_mul_sequencer_pkg::ALU_MUL
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  alu_mul_sequencer_if.slave bus
);

  state_t          state_q, state_d;
  logic            accept;
  logic            load, step, stall, last;
  logic [XLEN-1:0] acc_nxt;
  logic [XLEN-1:0] result_q, result_d;
  logic            result_valid_q, result_valid_d;

  assign accept = bus.valid_i && (bus.alu_ctrl_i == MUL_CODE) && !bus.flush_i;

  mul_shift_add_dp #(.XLEN(XLEN)) u_dp (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .step_i    (step),
    .mcand_i   (bus.rs1_data_i),
    .mplier_i  (bus.rs2_data_i),
    .acc_nxt_o (acc_nxt),
    .last_o    (last)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (last)   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush_i) state_d = ST_IDLE;
  end

  always_comb begin
    load  = 1'b0;
    step  = 1'b0;
    stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load  = accept;
        stall = accept;
      end
      ST_RUN: begin
        step  = !bus.flush_i;
        stall = !bus.flush_i;
      end
      default: ;
    endcase
  end

  // The product is latched on the RUN->DONE edge; a flush there discards it.
  assign result_valid_d = (state_q == ST_RUN) && last && !bus.flush_i;
  assign result_d       = result_valid_d ? acc_nxt : result_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Reset forces stall low even if a MUL is presented while still in reset.
  assign bus.stall_o        = stall && rst_i;
  assign bus.busy_o         = (state_q != ST_IDLE);
  assign bus.result_valid_o = result_valid_q;
  assign bus.result_o       = result_q;

endmodule
`default_nettype wire
